bayer_video_src: RTL and testbench



---
 rtl/bayer_video_src.sv | 209 ++++++++++++++++++++
 tb/tb_bayer_video_src.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bayer_video_src.sv
// Raster frame source for the demosaic pipeline.
// Generates VGA-style sync/enable timing, fetches raw Bayer pixels from an
// external synchronous memory in raster order, and presents them on a video
// port with hsync, vsync and de aligned to the pixel data.
//
// Pipeline (all timing signals travel down the same number of stages):
//   stage 0 : raster counters, combinational decode of sync/active windows
//   stage 1 : registered read strobe + address, sync delayed one clk
//   stage 2 : memory returns data; sync/active delayed a second clk
//   stage 3 : registered video outputs
//   stage 4 : frame_done pulse and completed-frame counter
module bayer_video_src #(
  parameter int   H_DISP   = 440,
  parameter int   V_DISP   = 400,
  parameter int   H_SYNC   = 4,
  parameter int   H_BACK   = 4,
  parameter int   H_FRONT  = 4,
  parameter int   V_SYNC   = 2,
  parameter int   V_BACK   = 2,
  parameter int   V_FRONT  = 2,
  parameter logic SYNC_POL = 1'b0,
  parameter int   ADDR_W   = 18,
  parameter int   DATA_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              vid_hsync,
  output logic              vid_vsync,
  output logic              vid_de,
  output logic [DATA_W-1:0] vid_data,
  output logic              frame_done,
  output logic [15:0]       frame_cnt
);

  // Raster geometry. Segment order on both axes: sync, back porch, active,
  // front porch.
  localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;
  localparam int H_ACT_S = H_SYNC + H_BACK;
  localparam int H_ACT_E = H_ACT_S + H_DISP;
  localparam int V_ACT_S = V_SYNC + V_BACK;
  localparam int V_ACT_E = V_ACT_S + V_DISP;
  localparam int N_PIX   = H_DISP * V_DISP;

  // Counter widths wide enough to hold H_TOTAL / V_TOTAL themselves, so the
  // window bounds below never truncate.
  localparam int HW = $clog2(H_TOTAL + 1);
  localparam int VW = $clog2(V_TOTAL + 1);

  localparam logic [HW-1:0]     H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0]     V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0]     H_SYNC_E = HW'(H_SYNC);
  localparam logic [VW-1:0]     V_SYNC_E = VW'(V_SYNC);
  localparam logic [HW-1:0]     H_ACT_LO = HW'(H_ACT_S);
  localparam logic [HW-1:0]     H_ACT_HI = HW'(H_ACT_E);
  localparam logic [VW-1:0]     V_ACT_LO = VW'(V_ACT_S);
  localparam logic [VW-1:0]     V_ACT_HI = VW'(V_ACT_E);
  localparam logic [ADDR_W-1:0] PIX_LAST = ADDR_W'(N_PIX - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [HW-1:0]     h_cnt;
  logic [VW-1:0]     v_cnt;
  logic [ADDR_W-1:0] rd_idx;

  // Stage 0 decode.
  logic running;
  logic h_last, v_last, frame_wrap;
  logic act0, sync_h0, sync_v0, last0;

  // Delayed copies of the timing flags. act1 is mem_rd itself.
  logic sync_h1, sync_v1, last1;
  logic act2, sync_h2, sync_v2, last2;
  logic last3;

  // ---------------------------------------------------------------------------
  // FSM state register.
  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: start on en from IDLE, re-sample en only at frame wrap.
  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (en) state_d = RUN;
      RUN:     if (frame_wrap && !en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Raster position flags.
  always_comb begin
    running    = (state_q == RUN);
    h_last     = (h_cnt == H_LAST);
    v_last     = (v_cnt == V_LAST);
    frame_wrap = running && h_last && v_last;
  end

  // ---------------------------------------------------------------------------
  // Horizontal/vertical raster counters; held at (0,0) outside RUN so a
  // restart always begins at the top-left of the frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (running) begin
      if (h_last) begin
        h_cnt <= '0;
        v_cnt <= v_last ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end else begin
      h_cnt <= '0;
      v_cnt <= '0;
    end
  end

  // Stage 0: decode sync and active windows from the counters.
  always_comb begin
    sync_h0 = running && (h_cnt < H_SYNC_E);
    sync_v0 = running && (v_cnt < V_SYNC_E);
    act0    = running
              && (h_cnt >= H_ACT_LO) && (h_cnt < H_ACT_HI)
              && (v_cnt >= V_ACT_LO) && (v_cnt < V_ACT_HI);
    last0   = act0 && (rd_idx == PIX_LAST);
  end

  // ---------------------------------------------------------------------------
  // Stage 1: issue the memory read. rd_idx is the running pixel index; it
  // returns to 0 after the last pixel so every frame starts at address 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_rd   <= 1'b0;
      mem_addr <= '0;
      rd_idx   <= '0;
      sync_h1  <= 1'b0;
      sync_v1  <= 1'b0;
      last1    <= 1'b0;
    end else begin
      mem_rd   <= act0;
      mem_addr <= act0 ? rd_idx : '0;
      if (act0) rd_idx <= last0 ? '0 : rd_idx + 1'b1;
      sync_h1  <= sync_h0;
      sync_v1  <= sync_v0;
      last1    <= last0;
    end
  end

  // Stage 2: memory data becomes valid; delay the timing flags to match.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act2    <= 1'b0;
      sync_h2 <= 1'b0;
      sync_v2 <= 1'b0;
      last2   <= 1'b0;
    end else begin
      act2    <= mem_rd;
      sync_h2 <= sync_h1;
      sync_v2 <= sync_v1;
      last2   <= last1;
    end
  end

  // Stage 3: register the video outputs; data is forced to 0 outside de and
  // syncs are mapped onto the configured polarity.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vid_de    <= 1'b0;
      vid_data  <= '0;
      vid_hsync <= ~SYNC_POL;
      vid_vsync <= ~SYNC_POL;
      last3     <= 1'b0;
    end else begin
      vid_de    <= act2;
      vid_data  <= act2 ? mem_data : '0;
      vid_hsync <= sync_h2 ~^ SYNC_POL;
      vid_vsync <= sync_v2 ~^ SYNC_POL;
      last3     <= last2;
    end
  end

  // Stage 4: end-of-frame pulse and completed-frame count (wraps naturally).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_done <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      frame_done <= last3;
      if (last3) frame_cnt <= frame_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_bayer_video_src.sv
// Bench for bayer_video_src. A small-geometry instance (4x2 active, all
// porches/syncs 1, active-low sync) is checked with a read/output scoreboard;
// a second instance (20x10, active-high sync) runs one full frame.
module tb_bayer_video_src;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- small DUT
  logic       s_rst, s_en, s_mem_rd, s_hs, s_vs, s_de, s_fd;
  logic [3:0] s_mem_addr;
  logic [7:0] s_mem_data, s_data;
  logic [15:0] s_fcnt;

  bayer_video_src #(
    .H_DISP(4), .V_DISP(2), .H_SYNC(1), .H_BACK(1), .H_FRONT(1),
    .V_SYNC(1), .V_BACK(1), .V_FRONT(1), .SYNC_POL(1'b0),
    .ADDR_W(4), .DATA_W(8)
  ) u_small (
    .clk(clk), .rst(s_rst), .en(s_en),
    .mem_rd(s_mem_rd), .mem_addr(s_mem_addr), .mem_data(s_mem_data),
    .vid_hsync(s_hs), .vid_vsync(s_vs), .vid_de(s_de), .vid_data(s_data),
    .frame_done(s_fd), .frame_cnt(s_fcnt)
  );

  // Synchronous memory: data = address, one clk after the strobe.
  always @(posedge clk) if (s_mem_rd) s_mem_data <= 8'(s_mem_addr);

  typedef struct {
    int unsigned due;
    logic [7:0]  data;
  } exp_t;

  exp_t        sb[$];
  int unsigned exp_addr     = 0;
  int          run_len      = 0;
  int          de_frame     = 0;
  int          hs_cnt       = 0;
  int          vs_cnt       = 0;
  bit          fd_seen      = 0;
  int unsigned last_pix_cyc = 0;
  int          last_pix_val = -1;
  bit          rd_arm       = 0;
  int unsigned rd_due       = 0;

  // Monitor: reads push expected pixels, de pops and compares.
  always @(negedge clk) begin
    if (!s_rst) begin
      if (s_mem_rd) begin
        if (rd_arm) begin
          check("first_rd_cycle", cyc, rd_due);
          rd_arm = 0;
        end
        check("rd_addr", s_mem_addr, exp_addr);
        sb.push_back('{due: cyc + 2, data: 8'(exp_addr)});
        exp_addr = (exp_addr == 7) ? 0 : exp_addr + 1;
      end
      if (s_de) begin
        run_len++;
        de_frame++;
        check("de_outside_sync", {s_hs, s_vs}, 2'b11);
        check("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          check("de_latency", cyc, e.due);
          check("pix", s_data, e.data);
          last_pix_cyc = cyc;
          last_pix_val = int'(s_data);
        end
      end else begin
        if (run_len != 0) begin
          check("line_de_len", run_len, 4);
          run_len = 0;
        end
        check("data_zero_no_de", s_data, 0);
      end
      if (!s_hs) hs_cnt++;
      if (!s_vs) vs_cnt++;
      if (s_fd) begin
        check("fd_after_last", cyc - last_pix_cyc, 1);
        check("fd_last_pix", last_pix_val, 7);
        check("fd_de_count", de_frame, 8);
        if (fd_seen) begin
          check("hsync_per_frame", hs_cnt, 5);
          check("vsync_per_frame", vs_cnt, 7);
        end
        fd_seen  = 1;
        de_frame = 0;
        hs_cnt   = 0;
        vs_cnt   = 0;
      end
    end
  end

  task automatic check_small_reset(input string p);
    check({p, "_mem_rd"},   s_mem_rd,   0);
    check({p, "_mem_addr"}, s_mem_addr, 0);
    check({p, "_de"},       s_de,       0);
    check({p, "_data"},     s_data,     0);
    check({p, "_hsync"},    s_hs,       1);
    check({p, "_vsync"},    s_vs,       1);
    check({p, "_fdone"},    s_fd,       0);
    check({p, "_fcnt"},     s_fcnt,     0);
  endtask

  // Wait for the next frame_done pulse, bounded; returns its cycle.
  task automatic wait_fd(input string tag, output int unsigned at);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!s_fd && n < 200);
    check({tag, "_fd_seen"}, s_fd, 1);
    at = cyc;
  endtask

  // ---------------------------------------------------------------- big DUT
  logic       b_rst, b_en, b_mem_rd, b_hs, b_vs, b_de, b_fd;
  logic [7:0] b_mem_addr, b_mem_data, b_data;
  logic [15:0] b_fcnt;

  bayer_video_src #(
    .H_DISP(20), .V_DISP(10), .H_SYNC(3), .H_BACK(2), .H_FRONT(5),
    .V_SYNC(2), .V_BACK(1), .V_FRONT(2), .SYNC_POL(1'b1),
    .ADDR_W(8), .DATA_W(8)
  ) u_big (
    .clk(clk), .rst(b_rst), .en(b_en),
    .mem_rd(b_mem_rd), .mem_addr(b_mem_addr), .mem_data(b_mem_data),
    .vid_hsync(b_hs), .vid_vsync(b_vs), .vid_de(b_de), .vid_data(b_data),
    .frame_done(b_fd), .frame_cnt(b_fcnt)
  );

  always @(posedge clk) if (b_mem_rd) b_mem_data <= b_mem_addr ^ 8'hA5;

  int          b_idx       = 0;
  int          b_run       = 0;
  int          b_hrun      = 0;
  int          b_vrun      = 0;
  int unsigned b_last_addr = 0;

  // Big-instance monitor: pixel i must carry i ^ A5; active-high sync widths.
  always @(negedge clk) begin
    if (!b_rst) begin
      if (b_mem_rd) b_last_addr = int'(b_mem_addr);
      if (b_de) begin
        check("b_pix", b_data, 8'(b_idx) ^ 8'hA5);
        check("b_de_outside_sync", {b_hs, b_vs}, 2'b00);
        b_idx++;
        b_run++;
      end else if (b_run != 0) begin
        check("b_line_de_len", b_run, 20);
        b_run = 0;
      end
      if (b_hs) b_hrun++;
      else if (b_hrun != 0) begin
        check("b_hsync_width", b_hrun, 3);
        b_hrun = 0;
      end
      if (b_vs) b_vrun++;
      else if (b_vrun != 0) begin
        check("b_vsync_width", b_vrun, 60);
        b_vrun = 0;
      end
    end
  end

  // ---------------------------------------------------------------- stimulus
  initial begin
    int unsigned k, f1, f2, f3, t;
    int n;
    logic any_de, any_rd, any_sync;

    s_rst = 1'b1; s_en = 1'b0;
    b_rst = 1'b1; b_en = 1'b0;
    repeat (3) @(negedge clk);
    check_small_reset("rst");
    check("b_rst_hsync", b_hs, 0);
    check("b_rst_vsync", b_vs, 0);

    // Continuous run: three frames, 35 clks apart.
    s_rst = 1'b0; s_en = 1'b1;
    k = cyc; rd_due = k + 18; rd_arm = 1;
    wait_fd("f1", f1);
    check("first_fd_cycle", f1, k + 31);
    check("fcnt_1", s_fcnt, 1);
    wait_fd("f2", f2);
    wait_fd("f3", f3);
    check("fd_period_a", f2 - f1, 35);
    check("fd_period_b", f3 - f2, 35);
    check("fcnt_3", s_fcnt, 3);

    // Reset mid-frame while pixel 5 is being read.
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(s_mem_rd && s_mem_addr == 4'd5) && n < 100);
    check("saw_addr5", s_mem_addr, 5);
    @(posedge clk);
    #2;
    s_rst = 1'b1;
    sb.delete();
    exp_addr = 0; run_len = 0; de_frame = 0; hs_cnt = 0; vs_cnt = 0;
    fd_seen = 0; last_pix_val = -1; rd_arm = 0;
    #1;
    check_small_reset("async_rst");
    @(negedge clk);
    s_rst = 1'b0;
    k = cyc; rd_due = k + 18; rd_arm = 1;
    wait_fd("r1", t);
    check("fcnt_after_rst", s_fcnt, 1);

    // Drop en partway into frame 2: frame completes, then IDLE.
    repeat (10) @(negedge clk);
    s_en = 1'b0;
    wait_fd("r2", t);
    check("fcnt_after_drop", s_fcnt, 2);
    repeat (10) @(negedge clk);
    any_de = 0; any_rd = 0; any_sync = 0;
    repeat (40) begin
      @(negedge clk);
      any_de   |= s_de;
      any_rd   |= s_mem_rd;
      any_sync |= (!s_hs || !s_vs);
    end
    check("idle_de", any_de, 0);
    check("idle_rd", any_rd, 0);
    check("idle_sync", any_sync, 0);
    check("idle_fcnt", s_fcnt, 2);

    // Restart from IDLE: address 0, same start latency.
    s_en = 1'b1;
    k = cyc; rd_due = k + 18; rd_arm = 1;
    wait_fd("r3", t);
    check("fcnt_restart", s_fcnt, 3);

    // Counter wrap: preset to 65535, next frame wraps to 0.
    repeat (5) @(negedge clk);
    force u_small.frame_cnt = 16'hFFFF;
    @(negedge clk);
    release u_small.frame_cnt;
    @(negedge clk);
    check("fcnt_preset", s_fcnt, 16'hFFFF);
    wait_fd("w1", t);
    check("fcnt_wrap", s_fcnt, 0);
    wait_fd("w2", t);
    check("fcnt_after_wrap", s_fcnt, 1);
    s_en = 1'b0;

    // Larger geometry, active-high sync, exactly one frame.
    @(negedge clk);
    b_rst = 1'b0; b_en = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!b_mem_rd && n < 500);
    check("b_first_rd", b_mem_rd, 1);
    b_en = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!b_fd && n < 1000);
    check("b_fd_seen", b_fd, 1);
    check("b_de_total", b_idx, 200);
    check("b_last_addr", b_last_addr, 199);
    check("b_fcnt", b_fcnt, 1);
    repeat (100) @(negedge clk);
    check("b_fcnt_idle", b_fcnt, 1);
    check("b_idle_de", b_de, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
